// File: rtl/terrain_pkg.sv
// Shared types and constants for the terrain renderer: FSM states, screen geometry, palette.
// Latency: none (declarations only).
// Backpressure: not applicable.
package terrain_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        DRAW = 2'd3
    } state_t;

    localparam int SCREEN_W  = 160;
    localparam int SCREEN_H  = 120;
    localparam int HEIGHT_W  = 9;
    localparam int RAM_DEPTH = 1024;
    localparam int RAM_AW    = $clog2(RAM_DEPTH);

    localparam logic [2:0] COLOUR_GROUND    = 3'b010;
    localparam logic [2:0] COLOUR_SKY       = 3'b000;
    localparam logic [2:0] COLOUR_HIGHLIGHT = 3'b111;

endpackage

// File: rtl/column_shader.sv
// Pixel colour for one row of a terrain column of height h; TERRAIN_RENDER_HIGHLIGHT_EN marks the crest.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module column_shader
    import terrain_pkg::*;
#(
    parameter int         ROWS          = SCREEN_H,
    parameter logic [2:0] GROUND_COLOUR = COLOUR_GROUND,
    parameter logic [2:0] SKY_COLOUR    = COLOUR_SKY
) (
    input  logic [6:0] row,
    input  logic [6:0] h,
    output logic [2:0] colour
);

    // row >= ROWS-h rewritten as row+h >= ROWS so nothing can underflow.
    logic [7:0] depth;
    assign depth = {1'b0, row} + {1'b0, h};

    // Ground below the terrain line, sky above it.
    always_comb begin
        colour = SKY_COLOUR;
        if (depth >= 8'(ROWS)) begin
`ifdef TERRAIN_RENDER_HIGHLIGHT_EN
            if ((h != 7'd0) && (depth == 8'(ROWS))) begin
                colour = COLOUR_HIGHLIGHT;
            end else begin
                colour = GROUND_COLOUR;
            end
`else
            colour = GROUND_COLOUR;
`endif
        end
    end

endmodule

// File: rtl/terrain_render.sv
// Redraws the terrain column by column from the height RAM; optional crest colour via TERRAIN_RENDER_HIGHLIGHT_EN.
// Latency: COLS*(ROWS+2) cycles per frame, plus two cycles for each height read retried under wr_active.
// Backpressure: wr_active stalls the column fetch; frame_tick while busy is dropped and flagged in overrun.
module terrain_render
    import terrain_pkg::*;
#(
    parameter int         COLS          = SCREEN_W,
    parameter int         ROWS          = SCREEN_H,
    parameter logic [2:0] GROUND_COLOUR = COLOUR_GROUND,
    parameter logic [2:0] SKY_COLOUR    = COLOUR_SKY
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                frame_tick,
    input  logic                wr_active,
    input  logic [HEIGHT_W-1:0] rd_data,
    output logic [RAM_AW-1:0]   rd_addr,
    output logic [7:0]          x,
    output logic [6:0]          y,
    output logic [2:0]          colour,
    output logic                plot,
    output logic                busy,
    output logic                done,
    output logic                overrun
);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] col;
    logic [6:0] row;
    logic [6:0] h;
    logic [7:0] x_hold;
    logic [6:0] y_hold;
    logic [2:0] colour_hold;
    logic [2:0] shade;
    logic       start;
    logic       capture;
    logic       frame_end;
    logic       last_row;
    logic       last_col;

    assign last_row = (row == 7'(ROWS - 1));
    assign last_col = (col == 8'(COLS - 1));

    column_shader #(
        .ROWS          (ROWS),
        .GROUND_COLOUR (GROUND_COLOUR),
        .SKY_COLOUR    (SKY_COLOUR)
    ) u_shader (
        .row    (row),
        .h      (h),
        .colour (shade)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and datapath enables.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        capture   = 1'b0;
        frame_end = 1'b0;
        case (state)
            IDLE: begin
                if (frame_tick) begin
                    state_nxt = ADDR;
                    start     = 1'b1;
                end
            end
            ADDR: state_nxt = WAIT;
            WAIT: begin
                // RAM contents are suspect while the scroller writes; re-issue the read.
                if (wr_active) begin
                    state_nxt = ADDR;
                end else begin
                    state_nxt = DRAW;
                    capture   = 1'b1;
                end
            end
            DRAW: begin
                if (last_row) begin
                    state_nxt = last_col ? IDLE : ADDR;
                    frame_end = last_col;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Column/row counters, captured height, held pixel outputs and status flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            col         <= 8'd0;
            row         <= 7'd0;
            h           <= 7'd0;
            x_hold      <= 8'd0;
            y_hold      <= 7'd0;
            colour_hold <= SKY_COLOUR;
            done        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            done <= frame_end;
            if (frame_tick && busy) begin
                overrun <= 1'b1;
            end
            if (start) begin
                col <= 8'd0;
            end
            if (capture) begin
                h   <= (rd_data >= HEIGHT_W'(ROWS)) ? 7'(ROWS) : rd_data[6:0];
                row <= 7'd0;
            end
            if (state == DRAW) begin
                x_hold      <= col;
                y_hold      <= row;
                colour_hold <= shade;
                if (last_row) begin
                    row <= 7'd0;
                    if (!last_col) begin
                        col <= col + 8'd1;
                    end
                end else begin
                    row <= row + 7'd1;
                end
            end
        end
    end

    assign rd_addr = RAM_AW'(col);
    assign busy    = (state != IDLE);
    assign plot    = (state == DRAW);
    assign x       = plot ? col   : x_hold;
    assign y       = plot ? row   : y_hold;
    assign colour  = plot ? shade : colour_hold;

endmodule

// File: tb/tb_terrain_render.sv
module tb_terrain_render;

    localparam int         COLS = 160;
    localparam int         ROWS = 120;
    localparam int         CPC  = ROWS + 2;
    localparam logic [2:0] GND  = 3'b010;
    localparam logic [2:0] SKY  = 3'b000;
    localparam logic [2:0] HI   = 3'b111;

    logic       clock = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       wr_active;
    logic [8:0] rd_data;
    logic [9:0] rd_addr;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;
    logic       overrun;

    terrain_render dut (
        .clock      (clock),
        .reset      (reset),
        .frame_tick (frame_tick),
        .wr_active  (wr_active),
        .rd_data    (rd_data),
        .rd_addr    (rd_addr),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    always #5 clock = ~clock;

    // Height RAM: one-cycle registered read.
    logic [8:0] ram [0:1023];
    always @(posedge clock) rd_data <= ram[rd_addr];

    int total = 0;
    int bad   = 0;

    // Per-frame record filled by run_frame.
    int         hd [0:COLS-1];
    logic [2:0] img [0:COLS-1][0:ROWS-1];
    int         wcnt [0:COLS-1][0:ROWS-1];
    int         busy_cnt, plot_cnt, done_cnt, addr_bad, cycles;

    function automatic logic [2:0] exp_colour(input int row, input int d);
        int hh;
        hh = (d > ROWS) ? ROWS : d;
        if (row < ROWS - hh) return SKY;
`ifdef TERRAIN_RENDER_HIGHLIGHT_EN
        if (hh > 0 && row == ROWS - hh) return HI;
`endif
        return GND;
    endfunction

    // Pulses frame_tick, then drives per-cycle stimulus and records outputs until busy drops.
    // Cycle 1 is the first cycle after the edge that sampled frame_tick.
    task automatic run_frame(input int stall_at, input int stall_len, input int stall_col,
                             input int stall_val, input int tick_at, input int reset_at,
                             input int max_cyc);
        busy_cnt = 0; plot_cnt = 0; done_cnt = 0; addr_bad = 0; cycles = 0;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++) begin
                wcnt[c][r] = 0;
                img[c][r]  = 3'bxxx;
            end
        frame_tick = 1'b1;
        @(posedge clock); #1;
        frame_tick = 1'b0;
        for (int n = 1; n <= max_cyc; n++) begin
            wr_active  = (n >= stall_at) && (n < stall_at + stall_len);
            if (n == stall_at) ram[stall_col] = 9'(stall_val);
            frame_tick = (n == tick_at);
            reset      = (n == reset_at);
            @(negedge clock);
            cycles = n;
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (plot) begin
                plot_cnt++;
                if (int'(x) < COLS && int'(y) < ROWS) begin
                    img[x][y]  = colour;
                    wcnt[x][y] = wcnt[x][y] + 1;
                end
                if (rd_addr != {2'b00, x}) addr_bad++;
            end
            if (!busy) break;
            @(posedge clock); #1;
        end
        wr_active  = 1'b0;
        frame_tick = 1'b0;
        reset      = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; frame_tick = 1'b0; wr_active = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        total++; if (plot !== 1'b0)      begin bad++; $display("FAIL rst_plot got=%b want=0", plot); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0)      begin bad++; $display("FAIL rst_done got=%b want=0", done); end
        total++; if (overrun !== 1'b0)   begin bad++; $display("FAIL rst_overrun got=%b want=0", overrun); end
        total++; if (x !== 8'd0)         begin bad++; $display("FAIL rst_x got=%0d want=0", x); end
        total++; if (y !== 7'd0)         begin bad++; $display("FAIL rst_y got=%0d want=0", y); end
        total++; if (colour !== SKY)     begin bad++; $display("FAIL rst_colour got=%b want=%b", colour, SKY); end
        total++; if (rd_addr !== 10'd0)  begin bad++; $display("FAIL rst_addr got=%0d want=0", rd_addr); end
        // reset wins over a simultaneous frame_tick
        frame_tick = 1'b1;
        @(posedge clock); #1;
        frame_tick = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_prio_busy got=%b want=0", busy); end
        repeat (3) @(posedge clock);
        @(negedge clock);
        total++; if (busy !== 1'b0 || plot !== 1'b0) begin
            bad++; $display("FAIL idle_no_start busy=%b plot=%b want=0,0", busy, plot);
        end
    endtask

    task automatic test_full_frame();
        for (int a = 0; a < 1024; a++) ram[a] = 9'(a % 130);
        for (int c = 0; c < COLS; c++) hd[c] = c % 130;
        run_frame(0, 0, 0, 0, 100, 0, 25000);
        total++; if (busy_cnt != COLS*CPC) begin bad++; $display("FAIL ff_busy_cycles got=%0d want=%0d", busy_cnt, COLS*CPC); end
        total++; if (cycles != COLS*CPC + 1) begin bad++; $display("FAIL ff_done_cycle got=%0d want=%0d", cycles, COLS*CPC + 1); end
        total++; if (plot_cnt != COLS*ROWS) begin bad++; $display("FAIL ff_plot_count got=%0d want=%0d", plot_cnt, COLS*ROWS); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL ff_done_count got=%0d want=1", done_cnt); end
        total++; if (done !== 1'b1 || plot !== 1'b0) begin bad++; $display("FAIL ff_end_state done=%b plot=%b want=1,0", done, plot); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ff_overrun got=%b want=1", overrun); end
        total++; if (addr_bad != 0) begin bad++; $display("FAIL ff_rd_addr bad_cycles=%0d want=0", addr_bad); end
        total++; if (x !== 8'(COLS-1) || y !== 7'(ROWS-1) || colour !== exp_colour(ROWS-1, hd[COLS-1])) begin
            bad++; $display("FAIL ff_hold x=%0d y=%0d colour=%b want=%0d,%0d,%b",
                            x, y, colour, COLS-1, ROWS-1, exp_colour(ROWS-1, hd[COLS-1]));
        end
        for (int c = 0; c < COLS; c++) begin
            int br;
            br = -1;
            for (int r = 0; r < ROWS; r++)
                if (br < 0 && (wcnt[c][r] != 1 || img[c][r] !== exp_colour(r, hd[c]))) br = r;
            total++;
            if (br >= 0) begin
                bad++;
                $display("FAIL ff_col%0d row=%0d got=%b writes=%0d want=%b", c, br, img[c][br], wcnt[c][br], exp_colour(br, hd[c]));
            end
        end
        // done must be a single-cycle pulse
        @(posedge clock); @(negedge clock);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL ff_done_pulse got=%b want=0", done); end
    endtask

    task automatic test_random_stall();
        int newv, extra, t, sat;
        for (int a = 0; a < 1024; a++) ram[a] = 9'($urandom_range(0, 511));
        ram[3] = 9'd30; ram[4] = 9'd0; ram[5] = 9'd200; ram[7] = 9'd5;
        newv = $urandom_range(10, 110);
        for (int c = 0; c < COLS; c++) hd[c] = int'(ram[c]);
        hd[7] = newv;
        // Column 7 reaches its fetch-check cycle at 7*CPC+2; each check seen with wr_active high
        // sends it back for another read, costing two cycles.
        sat = 7*CPC + 2;
        extra = 0;
        t = sat;
        while (t < sat + 5) begin extra += 2; t += 2; end
        // returns on the done cycle, so the back-to-back test can tick immediately
        @(posedge clock); #1;
        run_frame(sat, 5, 7, newv, 0, 0, 25000);
        total++; if (busy_cnt != COLS*CPC + extra) begin bad++; $display("FAIL st_busy_cycles got=%0d want=%0d", busy_cnt, COLS*CPC + extra); end
        total++; if (plot_cnt != COLS*ROWS) begin bad++; $display("FAIL st_plot_count got=%0d want=%0d", plot_cnt, COLS*ROWS); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL st_done_count got=%0d want=1", done_cnt); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL st_overrun_sticky got=%b want=1", overrun); end
        total++; if (img[3][89] !== SKY) begin bad++; $display("FAIL h30_row89 got=%b want=%b", img[3][89], SKY); end
`ifdef TERRAIN_RENDER_HIGHLIGHT_EN
        total++; if (img[3][90] !== HI) begin bad++; $display("FAIL h30_row90 got=%b want=%b", img[3][90], HI); end
`else
        total++; if (img[3][90] !== GND) begin bad++; $display("FAIL h30_row90 got=%b want=%b", img[3][90], GND); end
`endif
        total++; if (img[3][119] !== GND) begin bad++; $display("FAIL h30_row119 got=%b want=%b", img[3][119], GND); end
        total++; if (img[5][0] !== GND) begin bad++; $display("FAIL h200_row0 got=%b want=%b", img[5][0], GND); end
        total++; if (img[4][119] !== SKY) begin bad++; $display("FAIL h0_row119 got=%b want=%b", img[4][119], SKY); end
        for (int c = 0; c < COLS; c++) begin
            int br;
            br = -1;
            for (int r = 0; r < ROWS; r++)
                if (br < 0 && (wcnt[c][r] != 1 || img[c][r] !== exp_colour(r, hd[c]))) br = r;
            total++;
            if (br >= 0) begin
                bad++;
                $display("FAIL st_col%0d row=%0d got=%b writes=%0d want=%b", c, br, img[c][br], wcnt[c][br], exp_colour(br, hd[c]));
            end
        end
    endtask

    task automatic test_back_to_back_reset();
        int exp_plots;
        // tick lands in the done cycle of the previous frame; reset hits at cycle 5000
        run_frame(0, 0, 0, 0, 0, 5000, 6000);
        exp_plots = 0;
        for (int n = 1; n <= 5000; n++) if (((n - 1) % CPC) >= 2) exp_plots++;
        total++; if (busy_cnt != 5000) begin bad++; $display("FAIL b2b_busy_cycles got=%0d want=5000", busy_cnt); end
        total++; if (cycles != 5001) begin bad++; $display("FAIL abort_cycle got=%0d want=5001", cycles); end
        total++; if (plot_cnt != exp_plots) begin bad++; $display("FAIL abort_plot_count got=%0d want=%0d", plot_cnt, exp_plots); end
        total++; if (done_cnt != 0) begin bad++; $display("FAIL abort_done_count got=%0d want=0", done_cnt); end
        total++; if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0) begin
            bad++; $display("FAIL abort_flags plot=%b busy=%b done=%b overrun=%b want=0000", plot, busy, done, overrun);
        end
        total++; if (x !== 8'd0 || y !== 7'd0 || colour !== SKY) begin
            bad++; $display("FAIL abort_pixel x=%0d y=%0d colour=%b want=0,0,%b", x, y, colour, SKY);
        end
        done_cnt = 0; plot_cnt = 0;
        repeat (4) begin
            @(negedge clock);
            if (done) done_cnt++;
            if (plot) plot_cnt++;
        end
        total++; if (done_cnt != 0 || plot_cnt != 0) begin
            bad++; $display("FAIL abort_quiet done=%0d plot=%0d want=0,0", done_cnt, plot_cnt);
        end
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; wr_active = 1'b0;
        for (int a = 0; a < 1024; a++) ram[a] = 9'd0;
        test_reset();
        test_full_frame();
        test_random_stall();
        test_back_to_back_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/terrain_render.md
TERRAIN_RENDER -- requirements
Module: terrain_render

Interface
REQ-001 Parameter: COLS, default 160, screen columns drawn per frame.
REQ-002 Parameter: ROWS, default 120, screen rows per column.
REQ-003 Parameter: GROUND_COLOUR, default 3'b010, colour of ground pixels.
REQ-004 Parameter: SKY_COLOUR, default 3'b000, colour of sky pixels.
REQ-005 Port: clock  in  1  single system clock; all logic on its rising edge.
REQ-006 Port: reset  in  1  synchronous, active-high reset.
REQ-007 Port: frame_tick  in  1  one-cycle pulse; requests one full frame redraw.
REQ-008 Port: wr_active  in  1  high while the scroll stage writes the height RAM; reads are not trusted.
REQ-009 Port: rd_data  in  9  height word from the 1024x9 height RAM.
REQ-010 Port: rd_addr  out  10  height RAM read address.
REQ-011 Port: x  out  8  pixel column to the VGA adapter.
REQ-012 Port: y  out  7  pixel row to the VGA adapter; 0 is the top row.
REQ-013 Port: colour  out  3  pixel colour.
REQ-014 Port: plot  out  1  pixel write strobe.
REQ-015 Port: busy  out  1  high from frame start until done.
REQ-016 Port: done  out  1  one-cycle pulse after the last pixel of a frame.
REQ-017 Port: overrun  out  1  sticky; set when frame_tick arrives while busy.

Function
REQ-018 FSM states SHALL be IDLE, ADDR, WAIT, DRAW.
REQ-019 rd_addr SHALL equal zero-extended column counter col (0..COLS-1) at all times.
REQ-020 IDLE with frame_tick: col=0 and next state ADDR; busy rises on the same edge.
REQ-021 ADDR SHALL last one cycle, then WAIT; RAM read latency is one cycle after the address edge.
REQ-022 WAIT: if wr_active=0, capture h=min(rd_data,ROWS), row=0, go to DRAW; if wr_active=1, return to ADDR (stall, no capture).
REQ-023 DRAW: plot=1 every cycle; x=col, y=row; colour=GROUND_COLOUR when row >= ROWS-h, else SKY_COLOUR.
REQ-024 DRAW lasts exactly ROWS cycles per column; at row=ROWS-1, if col=COLS-1 go to IDLE with done=1 next cycle, else col+1 and go to ADDR.
REQ-025 Unstalled frame length SHALL be COLS*(ROWS+2) cycles: 19520 at defaults.
REQ-026 plot SHALL be 0 in IDLE, ADDR and WAIT; x, y, colour hold last values there.
REQ-027 rd_data >= ROWS SHALL draw a full ground column; rd_data=0 SHALL draw a full sky column.
REQ-028 frame_tick while busy SHALL be ignored (no restart) and SHALL set overrun.
REQ-029 frame_tick on the same cycle as done SHALL start a new frame (FSM is in IDLE that cycle).
REQ-030 The row and col comparisons SHALL not wrap: row is 7 bits, col is 8 bits, and both are bounded explicitly.

Reset
REQ-031 reset SHALL force IDLE, col=0, row=0, h=0, x=0, y=0, colour=SKY_COLOUR, plot=0, busy=0, done=0, overrun=0.
REQ-032 reset mid-frame SHALL abort immediately; plot=0 the next cycle, with no done pulse.
REQ-033 reset SHALL take priority over frame_tick on the same cycle.

Configuration
REQ-034 Macro TERRAIN_RENDER_HIGHLIGHT_EN defined: the topmost ground pixel (row=ROWS-h, h>0) SHALL use colour 3'b111.
REQ-035 Macro absent: every ground pixel SHALL use GROUND_COLOUR; timing is identical in both builds.

Structure
REQ-036 Shared package terrain_pkg SHALL hold the FSM state enum, SCREEN_W=160, SCREEN_H=120, HEIGHT_W=9, RAM_DEPTH=1024 and the colour constants.
REQ-037 One sub-module, column_shader, SHALL be combinational: row, h -> colour, and it contains the HIGHLIGHT option.

Verification
REQ-038 RAM model: addr c holds c mod 130; one frame_tick -> 19520 cycles busy, exactly 19200 plot cycles, done once.
REQ-039 Column with rd_data=30 -> rows 0..89 SKY_COLOUR, rows 90..119 GROUND_COLOUR; with HIGHLIGHT_EN, row 90 is 3'b111.
REQ-040 rd_data=0 -> all sky; rd_data=200 -> all ground, no wrap.
REQ-041 wr_active held high for 5 cycles during WAIT of col 7 -> col 7 is drawn with post-stall data; frame length is 19520 plus the stall cycles.
REQ-042 Second frame_tick at cycle 100 -> no restart, overrun=1 and stays 1 until reset.
REQ-043 reset asserted at cycle 5000 -> next cycle plot=0, busy=0, all outputs at reset values, no done pulse.
